// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM:
// state enum, opcode values and datapath mux/ALU select codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_BNEEX   = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ANDIEX  = 4'd11,
      S_ORIEX   = 4'd12,
      S_IMMWB   = 4'd13,
      S_JEX     = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_instret_ctr.sv
// 32-bit retired-instruction counter: increments when en_i is high,
// asynchronous active-low clear, wraps naturally at 2^32.
module mc_instret_ctr (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Next count: hold or increment by one.
   always_comb begin
      count_d = count_q;
      if (en_i) count_d = count_q + 32'd1;
   end

   // Counter register with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= 32'd0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multi-cycle MIPS core. Moore control outputs per
// state, PC enable from the branch zero flag, illegal-opcode pulse and a
// retired-instruction count. Build macro MCFSM_MEMWAIT_EN: when defined the
// FETCH/MEMRD/MEMWR states wait for mem_ready; otherwise mem_ready is ignored.
// Handshake: mem_ready=1 in FETCH/MEMRD/MEMWR means the access completes on
// the coming rising edge; the FSM holds its state and strobes until then.
// state_dbg exposes the current state encoding (mc_ctrl_pkg::state_t).
module mc_main_fsm
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pcen,
   output logic        irwrite,
   output logic        memwrite,
   output logic        regwrite,
   output logic        iord,
   output logic        memtoreg,
   output logic        regdst,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic        zeroext,
   output logic [1:0]  pcsrc,
   output logic [2:0]  aluop,
   output logic        illegal,
   output logic [31:0] instret,
   output logic [3:0]  state_dbg
);

   state_t state_q, state_d;
   logic   mem_rdy;
   logic   pcwrite, beq_st, bne_st, retire;
   logic   irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

`ifdef MCFSM_MEMWAIT_EN
   assign mem_rdy = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_rdy = 1'b1;
`endif

   // State register; reset aborts any in-flight instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next state, Moore controls and retire detection.
   always_comb begin
      state_d      = state_q;
      pcwrite      = 1'b0;
      beq_st       = 1'b0;
      bne_st       = 1'b0;
      retire       = 1'b0;
      irwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      regwrite_raw = 1'b0;
      illegal_raw  = 1'b0;
      iord         = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = SRCB_B;
      zeroext      = 1'b0;
      pcsrc        = PCSRC_ALU;
      aluop        = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            alusrcb     = SRCB_FOUR;
            irwrite_raw = mem_rdy;
            pcwrite     = mem_rdy;
            if (mem_rdy) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = SRCB_IMMSH;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_BNE:       state_d = S_BNEEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_ANDI:      state_d = S_ANDIEX;
               OP_ORI:       state_d = S_ORIEX;
               OP_J:         state_d = S_JEX;
               default: begin
                  illegal_raw = 1'b1;
                  state_d     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (mem_rdy) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite_raw = 1'b1;
            memtoreg     = 1'b1;
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
            if (mem_rdy) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
            state_d = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            regwrite_raw = 1'b1;
            regdst       = 1'b1;
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_BEQEX, S_BNEEX: begin
            beq_st  = (state_q == S_BEQEX);
            bne_st  = (state_q == S_BNEEX);
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_ADDIEX, S_ANDIEX, S_ORIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            if (state_q == S_ANDIEX) begin
               aluop   = ALUOP_AND;
               zeroext = 1'b1;
            end else if (state_q == S_ORIEX) begin
               aluop   = ALUOP_OR;
               zeroext = 1'b1;
            end
            state_d = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite_raw = 1'b1;
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Write enables and the illegal pulse are suppressed while reset is low.
   assign pcen      = reset & (pcwrite | (beq_st & zero) | (bne_st & ~zero));
   assign irwrite   = reset & irwrite_raw;
   assign memwrite  = reset & memwrite_raw;
   assign regwrite  = reset & regwrite_raw;
   assign illegal   = reset & illegal_raw;
   assign state_dbg = state_q;

   mc_instret_ctr u_instret (
      .clk_i   (clk),
      .rst_ni  (reset),
      .en_i    (retire),
      .count_o (instret)
   );

endmodule
